// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared FSM state type and mode encodings
// for the decoder_seq block and its dwell timer.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_seq_dwell_timer.sv
// dwell_timer: DWELL-cycle down-counter, built with DECODER_SEQ_SCAN_EN.
// Ports: clk_i, rst_i (sync high), clr_i, load_i, run_i, expire_o.
`ifdef DECODER_SEQ_SCAN_EN
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Loading DWELL-1 and expiring at zero gives exactly
  // DWELL cycles between consecutive loads.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = RELOAD;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-one-hot decoder with sel handshake
// and an optional dwell scan mode, enabled by macro DECODER_SEQ_SCAN_EN.
// Ports: clk, rst (sync active-high), en, mode (0 direct / 1 scan),
//   sel, sel_valid, sel_ready (comb), d, d_valid, wrap (scan wrap
//   pulse), err (sticky out-of-range select flag).
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  output logic [NUM_OUT-1:0] d,
  output logic               d_valid,
  output logic               wrap,
  output logic               err
);

  localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);

  state_e             state_q;
  logic [NUM_OUT-1:0] d_q;
  logic               d_valid_q;
  logic               wrap_q;
  logic               err_q;

  logic mode_eff;
  logic accept;
  logic in_range;
  logic acc_ok;
  logic acc_bad;

`ifdef DECODER_SEQ_SCAN_EN
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_nxt;
  logic             in_scan;
  logic             scan_enter;
  logic             scan_exit;
  logic             scan_step;
  logic             last_idx;
  logic             tmr_clr;
  logic             tmr_load;
  logic             tmr_run;
  logic             tmr_expire;

  assign mode_eff   = (mode == MODE_SCAN);
  assign in_scan    = (state_q == SCAN);
  assign scan_enter = mode_eff & ~in_scan;
  assign scan_exit  = in_scan & ~mode_eff;
  assign scan_step  = in_scan & mode_eff & tmr_expire;

  // Wrap back to 0 at NUM_OUT-1 so indices >= NUM_OUT are never visited.
  assign last_idx = (idx_q == LAST);
  assign idx_nxt  = last_idx ? '0 : idx_q + SEL_W'(1);

  assign tmr_clr  = ~en | ~mode_eff;
  assign tmr_load = en & (scan_enter | scan_step);
  assign tmr_run  = en & in_scan & mode_eff;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (tmr_clr),
    .load_i   (tmr_load),
    .run_i    (tmr_run),
    .expire_o (tmr_expire)
  );
`else
  // Scan not built: mode is ignored.
  logic mode_unused;
  assign mode_unused = mode;
  assign mode_eff    = MODE_DIRECT;
`endif

  assign sel_ready = en & ~mode_eff & (state_q != SCAN);
  assign accept    = sel_valid & sel_ready;
  assign in_range  = int'(sel) < NUM_OUT;
  assign acc_ok    = accept & in_range;
  assign acc_bad   = accept & ~in_range;

  // rst and en low share one path: both abort everything,
  // clear err and suppress any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q   <= IDLE;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
      idx_q     <= '0;
`endif
    end else begin
      wrap_q <= 1'b0;
      unique case (1'b1)
`ifdef DECODER_SEQ_SCAN_EN
        scan_enter: begin
          state_q   <= SCAN;
          idx_q     <= '0;
          d_q       <= ONE;
          d_valid_q <= 1'b1;
        end
        scan_exit: begin
          state_q   <= IDLE;
          d_q       <= '0;
          d_valid_q <= 1'b0;
        end
        scan_step: begin
          idx_q  <= idx_nxt;
          d_q    <= ONE << idx_nxt;
          wrap_q <= last_idx;
        end
`endif
        acc_ok: begin
          state_q   <= HOLD;
          d_q       <= ONE << sel;
          d_valid_q <= 1'b1;
        end
        acc_bad: begin
          state_q   <= IDLE;
          d_q       <= '0;
          d_valid_q <= 1'b0;
          err_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign wrap    = wrap_q;
  assign err     = err_q;

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The module SHALL take parameter SEL_W, default 3, as the select width in bits.
REQ-002 The module SHALL take parameter NUM_OUT, default 8, as the number of one-hot outputs, with 2 <= NUM_OUT <= 2**SEL_W.
REQ-003 The module SHALL take parameter DWELL, default 4, as the cycles each output is held in scan mode, with DWELL >= 1.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-005 Port en: input, 1 bit, global enable.
REQ-006 Port mode: input, 1 bit; 0 = direct, 1 = scan.
REQ-007 Port sel: input, SEL_W bits, binary select in direct mode.
REQ-008 Port sel_valid: input, 1 bit, sel offered.
REQ-009 Port sel_ready: output, 1 bit, block can accept sel.
REQ-010 Port d: output, NUM_OUT bits, registered one-hot or all-zero decode.
REQ-011 Port d_valid: output, 1 bit, d holds a valid decode.
REQ-012 Port wrap: output, 1 bit, one-cycle pulse at scan wrap-around.
REQ-013 Port err: output, 1 bit, sticky flag for out-of-range select.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, HOLD and SCAN.
REQ-015 sel_ready SHALL be combinational, equal to en & ~mode & (state != SCAN).
REQ-016 A select SHALL be accepted on a cycle where sel_valid & sel_ready; d SHALL update on the next rising edge, giving 1-cycle latency.
REQ-017 On acceptance with sel < NUM_OUT: d <= 1 << sel, d_valid <= 1, state <= HOLD.
REQ-018 On acceptance with sel >= NUM_OUT: d <= 0, d_valid <= 0, err <= 1, state <= IDLE.
REQ-019 err SHALL clear only on rst or on en low.
REQ-020 In HOLD, d SHALL keep its value until a new accept, a mode change or en low.
REQ-021 A back-to-back accept in HOLD SHALL replace d with no bubble cycle.
REQ-022 With en = 1 and mode = 1 in IDLE or HOLD, state SHALL go to SCAN, idx <= 0, d <= 1, d_valid <= 1.
REQ-023 In SCAN, each idx SHALL be held for exactly DWELL cycles, then idx <= idx + 1.
REQ-024 When idx = NUM_OUT-1 at dwell expiry, idx <= 0 and wrap SHALL pulse high for the cycle d returns to bit 0.
REQ-025 When NUM_OUT is not a power of two, scan SHALL never visit an index >= NUM_OUT.
REQ-026 Dropping mode to 0 during SCAN SHALL give d <= 0, d_valid <= 0, state <= IDLE on the next edge, and no wrap pulse.
REQ-027 While in SCAN, sel_valid SHALL be ignored.
REQ-028 With en = 0, on the next edge d <= 0, d_valid <= 0, wrap <= 0, err <= 0, state <= IDLE, dwell counter <= 0.
REQ-029 en = 0 SHALL take priority over every other input.
REQ-030 When en falls on the same cycle as an accept, the accept SHALL be discarded.
REQ-031 d SHALL never have more than one bit set.

Reset
REQ-032 rst SHALL be sampled only on the rising edge of clk.
REQ-033 rst SHALL take priority over en and all other inputs.
REQ-034 After reset, the outputs SHALL be d = 0, d_valid = 0, wrap = 0 and err = 0, and sel_ready SHALL follow REQ-015.
REQ-035 After reset, the internal state SHALL be state = IDLE, idx = 0 and dwell counter = 0.
REQ-036 Reset asserted mid-scan or mid-hold SHALL abort the operation with no wrap pulse.

Configuration
REQ-037 Macro DECODER_SEQ_SCAN_EN defined: scan mode, the SCAN state, the dwell timer and the wrap output SHALL be built as specified.
REQ-038 Macro DECODER_SEQ_SCAN_EN undefined: mode SHALL be ignored and treated as 0, there SHALL be no SCAN state, wrap SHALL be tied to 0, and no dwell timer logic SHALL be present.

Structure
REQ-039 Package decoder_seq_pkg SHALL hold the state enum (IDLE, HOLD, SCAN).
REQ-040 Package decoder_seq_pkg SHALL hold the mode constants MODE_DIRECT = 0 and MODE_SCAN = 1.
REQ-041 Sub-module dwell_timer SHALL be a parametrised DWELL down-counter with load and clear inputs and an expire output, instantiated only under DECODER_SEQ_SCAN_EN.

Verification
REQ-042 Reset and direct accept: with defaults, rst then en = 1, mode = 0, sel = 5, sel_valid pulse -> next cycle d = 8'b0010_0000, d_valid = 1, err = 0.
REQ-043 Out-of-range select: NUM_OUT = 6, sel = 7 accepted -> d = 0, d_valid = 0, err = 1; err stays 1 until en is low for 1 cycle.
REQ-044 Scan sequence: DWELL = 4, NUM_OUT = 6, mode = 1 -> d walks bit 0..5 at 4 cycles each; wrap pulses exactly on the 25th cycle after entry, when d returns to bit 0.
REQ-045 Mid-scan abort: mode -> 0 at idx = 3 -> next cycle d = 0, d_valid = 0, wrap = 0, sel_ready = 1.
REQ-046 Enable and reset priority: en drops on the same cycle as an accept of sel = 2 -> d stays 0; rst mid-HOLD -> all outputs 0 on the next edge.
REQ-047 Macro off: build without DECODER_SEQ_SCAN_EN, drive mode = 1 -> behaves as direct mode and wrap stays 0.
